// File: rtl/change_payout_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : change_payout_ctrl
// Purpose  : Greedy coin-tube change payout with per-tube inventory tracking.
// Revision : 1.0 - initial release
// ============================================================================
module change_payout_ctrl #(
  parameter int CNT_W     = 8,
  parameter int TUBE_INIT = 20,
  parameter int LOW_THR   = 2
) (
  input  logic        CLK,
  input  logic        I_RESET,
  input  logic        I_START,
  input  logic [15:0] I_AMOUNT,
  input  logic        I_COIN_VALID,
  input  logic [2:0]  I_COIN_CODE,
  input  logic        I_EJECT_ACK,
  output logic        O_EJECT_REQ,
  output logic [2:0]  O_EJECT_CODE,
  output logic        O_BUSY,
  output logic        O_DONE,
  output logic [15:0] O_SHORT,
  output logic        O_LOW_CHANGE
);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_select = 2'd1;
  localparam logic [1:0] c_eject  = 2'd2;
  localparam logic [1:0] c_done   = 2'd3;

  localparam logic [CNT_W-1:0] c_init = CNT_W'(TUBE_INIT);
  localparam logic [CNT_W-1:0] c_low  = CNT_W'(LOW_THR);
  localparam logic [CNT_W-1:0] c_max  = '1;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [15:0]      r_rem;
  logic [2:0]       r_code;
  logic [15:0]      r_short;
  logic [CNT_W-1:0] r_cnt [0:4];
  logic             w_found;
  logic [2:0]       w_sel_code;
  logic             w_ack;
  logic [4:0]       w_inc;
  logic [4:0]       w_dec;

  function automatic logic [15:0] denom(input logic [2:0] code);
    case (code)
      3'd0:    denom = 16'd1;
      3'd1:    denom = 16'd5;
      3'd2:    denom = 16'd10;
      3'd3:    denom = 16'd25;
      3'd4:    denom = 16'd100;
      default: denom = 16'd0;
    endcase
  endfunction

  // Denominations rise with the code, so the last match is the largest coin.
  always_comb begin
    w_found    = 1'b0;
    w_sel_code = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if ((r_cnt[i] != '0) && (denom(3'(i)) <= r_rem)) begin
        w_found    = 1'b1;
        w_sel_code = 3'(i);
      end
    end
  end

  assign w_ack = (r_state == c_eject) && I_EJECT_ACK;

  always_comb begin
    w_inc = 5'd0;
    w_dec = 5'd0;
    for (int i = 0; i < 5; i++) begin
      w_inc[i] = I_COIN_VALID && (I_COIN_CODE == 3'(i));
      w_dec[i] = w_ack && (r_code == 3'(i));
    end
  end

  always_ff @(posedge CLK) begin
    if (I_RESET) r_state <= c_idle;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle:   if (I_START) w_next = c_select;
      c_select: w_next = ((r_rem == 16'd0) || !w_found) ? c_done : c_eject;
      c_eject:  if (I_EJECT_ACK) w_next = c_select;
      c_done:   w_next = c_idle;
      default:  w_next = c_idle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (I_RESET) begin
      r_rem   <= 16'd0;
      r_code  <= 3'd0;
      r_short <= 16'd0;
      for (int i = 0; i < 5; i++) r_cnt[i] <= c_init;
    end else begin
      if ((r_state == c_idle) && I_START) r_rem <= I_AMOUNT;
      if ((r_state == c_select) && (w_next == c_eject)) r_code <= w_sel_code;
      if ((r_state == c_select) && (w_next == c_done)) r_short <= r_rem;
      if (w_ack) r_rem <= r_rem - denom(r_code);
      // A simultaneous insert and eject on one tube leaves its count as is.
      for (int i = 0; i < 5; i++) begin
        if (w_inc[i] && !w_dec[i]) begin
          if (r_cnt[i] != c_max) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end else if (w_dec[i] && !w_inc[i]) begin
          r_cnt[i] <= r_cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    O_EJECT_REQ = (r_state == c_eject);
    O_BUSY      = (r_state != c_idle);
    O_DONE      = (r_state == c_done);
  end

  assign O_EJECT_CODE = r_code;
  assign O_SHORT      = r_short;
  assign O_LOW_CHANGE = (r_cnt[1] < c_low) || (r_cnt[2] < c_low) || (r_cnt[3] < c_low);

endmodule
`default_nettype wire

// File: tb/tb_change_payout_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_change_payout_ctrl
// Purpose  : Directed self-checking bench for change_payout_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_change_payout_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, coin_valid, ack;
  logic [15:0] amount;
  logic [2:0]  coin_code;
  logic        req, busy, done, low;
  logic [2:0]  code;
  logic [15:0] short_o;

  logic        b_rst, b_start, b_coin_valid, b_ack;
  logic [15:0] b_amount;
  logic [2:0]  b_coin_code;
  logic        b_req, b_busy, b_done, b_low;
  logic [2:0]  b_code;
  logic [15:0] b_short;

  int          checks = 0;
  int          errors = 0;
  logic [2:0]  obs_code [16];
  int          obs_n;
  logic        obs_done;
  logic [15:0] obs_short;

  always #5 clk = ~clk;

  change_payout_ctrl dut (
    .CLK(clk), .I_RESET(rst), .I_START(start), .I_AMOUNT(amount),
    .I_COIN_VALID(coin_valid), .I_COIN_CODE(coin_code), .I_EJECT_ACK(ack),
    .O_EJECT_REQ(req), .O_EJECT_CODE(code), .O_BUSY(busy), .O_DONE(done),
    .O_SHORT(short_o), .O_LOW_CHANGE(low)
  );

  change_payout_ctrl #(.TUBE_INIT(1), .LOW_THR(1)) dut1 (
    .CLK(clk), .I_RESET(b_rst), .I_START(b_start), .I_AMOUNT(b_amount),
    .I_COIN_VALID(b_coin_valid), .I_COIN_CODE(b_coin_code), .I_EJECT_ACK(b_ack),
    .O_EJECT_REQ(b_req), .O_EJECT_CODE(b_code), .O_BUSY(b_busy), .O_DONE(b_done),
    .O_SHORT(b_short), .O_LOW_CHANGE(b_low)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_payout(input logic [15:0] amt);
    start  = 1'b1;
    amount = amt;
    tick();
    start  = 1'b0;
  endtask

  // Acts as the ejector: acks each request after dly cycles, records codes.
  task automatic serve(input int dly);
    obs_n    = 0;
    obs_done = 1'b0;
    for (int cyc = 0; cyc < 300 && !obs_done; cyc++) begin
      if (done) begin
        obs_done  = 1'b1;
        obs_short = short_o;
      end else if (req) begin
        if (obs_n < 16) obs_code[obs_n] = code;
        obs_n++;
        repeat (dly) tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
      end else begin
        tick();
      end
    end
    checks++;
    if (obs_done !== 1'b1) begin
      errors++;
      $display("FAIL serve_timeout got done=%0b exp done=1", obs_done);
    end
    tick();
  endtask

  task automatic test_reset();
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL rst_req got=%0b exp=0", req); end
    checks++; if (code !== 3'd0) begin errors++; $display("FAIL rst_code got=%0d exp=0", code); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%0b exp=0", done); end
    checks++; if (short_o !== 16'd0) begin errors++; $display("FAIL rst_short got=%0d exp=0", short_o); end
    checks++; if (low !== 1'b0) begin errors++; $display("FAIL rst_low got=%0b exp=0", low); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut.r_cnt[i] !== 8'd20) begin
        errors++; $display("FAIL rst_cnt%0d got=%0d exp=20", i, dut.r_cnt[i]);
      end
    end
  endtask

  task automatic test_zero_amount();
    start_payout(16'd0);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL zero_sel got busy=%0b done=%0b exp busy=1 done=0", busy, done); end
    tick();
    checks++; if (done !== 1'b1 || req !== 1'b0) begin errors++; $display("FAIL zero_done got done=%0b req=%0b exp done=1 req=0", done, req); end
    checks++; if (short_o !== 16'd0) begin errors++; $display("FAIL zero_short got=%0d exp=0", short_o); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL zero_idle got busy=%0b done=%0b exp 0 0", busy, done); end
  endtask

  task automatic test_greedy_65();
    logic [2:0] exp_c [4];
    int         exp_cnt [5];
    exp_c   = '{3'd3, 3'd3, 3'd2, 3'd1};
    exp_cnt = '{20, 19, 19, 18, 20};
    start_payout(16'd65);
    checks++; if (busy !== 1'b1 || req !== 1'b0) begin errors++; $display("FAIL lat_sel got busy=%0b req=%0b exp busy=1 req=0", busy, req); end
    tick();
    checks++; if (req !== 1'b1 || code !== 3'd3) begin errors++; $display("FAIL lat_req got req=%0b code=%0d exp req=1 code=3", req, code); end
    serve(1);
    checks++; if (obs_n !== 4) begin errors++; $display("FAIL g65_ncoins got=%0d exp=4", obs_n); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_code[i] !== exp_c[i]) begin errors++; $display("FAIL g65_code%0d got=%0d exp=%0d", i, obs_code[i], exp_c[i]); end
    end
    checks++; if (obs_short !== 16'd0) begin errors++; $display("FAIL g65_short got=%0d exp=0", obs_short); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL g65_idle got busy=%0b exp=0", busy); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut.r_cnt[i] !== 8'(exp_cnt[i])) begin errors++; $display("FAIL g65_cnt%0d got=%0d exp=%0d", i, dut.r_cnt[i], exp_cnt[i]); end
    end
  endtask

  task automatic test_ack_stall();
    start_payout(16'd30);
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (req !== 1'b1 || code !== 3'd3 || dut.r_cnt[3] !== 8'd18) begin
        errors++; $display("FAIL stall_hold%0d got req=%0b code=%0d cnt25=%0d exp 1 3 18", i, req, code, dut.r_cnt[3]);
      end
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (dut.r_cnt[3] !== 8'd17) begin errors++; $display("FAIL stall_dec got=%0d exp=17", dut.r_cnt[3]); end
    serve(0);
    checks++; if (obs_n !== 1 || obs_code[0] !== 3'd1) begin errors++; $display("FAIL stall_rest got n=%0d code=%0d exp n=1 code=1", obs_n, obs_code[0]); end
    checks++; if (dut.r_cnt[1] !== 8'd18) begin errors++; $display("FAIL stall_cnt5 got=%0d exp=18", dut.r_cnt[1]); end
  endtask

  task automatic test_start_while_busy();
    logic [2:0] exp_c [3];
    exp_c = '{3'd3, 3'd2, 3'd1};
    start_payout(16'd40);
    start  = 1'b1;
    amount = 16'd500;
    tick();
    start  = 1'b0;
    serve(1);
    checks++; if (obs_n !== 3) begin errors++; $display("FAIL busy_ncoins got=%0d exp=3", obs_n); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_code[i] !== exp_c[i]) begin errors++; $display("FAIL busy_code%0d got=%0d exp=%0d", i, obs_code[i], exp_c[i]); end
    end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_no_restart got busy=%0b exp=0", busy); end
  endtask

  task automatic test_coin_insert();
    int exp_cnt [5];
    exp_cnt = '{20, 17, 18, 16, 20};
    start_payout(16'd25);
    tick();
    ack        = 1'b1;
    coin_valid = 1'b1;
    coin_code  = 3'd3;
    tick();
    ack        = 1'b0;
    coin_valid = 1'b0;
    checks++; if (dut.r_cnt[3] !== 8'd16) begin errors++; $display("FAIL coin_same_tube got=%0d exp=16", dut.r_cnt[3]); end
    serve(1);
    checks++; if (obs_short !== 16'd0) begin errors++; $display("FAIL coin_short got=%0d exp=0", obs_short); end
    coin_valid = 1'b1;
    coin_code  = 3'd6;
    tick();
    coin_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut.r_cnt[i] !== 8'(exp_cnt[i])) begin errors++; $display("FAIL coin_code6_cnt%0d got=%0d exp=%0d", i, dut.r_cnt[i], exp_cnt[i]); end
    end
    coin_valid = 1'b1;
    coin_code  = 3'd4;
    tick();
    coin_valid = 1'b0;
    checks++; if (dut.r_cnt[4] !== 8'd21) begin errors++; $display("FAIL coin_inc100 got=%0d exp=21", dut.r_cnt[4]); end
  endtask

  task automatic test_reset_mid_eject();
    logic seen_done;
    start_payout(16'd100);
    tick();
    checks++; if (req !== 1'b1 || code !== 3'd4) begin errors++; $display("FAIL rme_req got req=%0b code=%0d exp 1 4", req, code); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rme_idle got req=%0b busy=%0b done=%0b exp 0 0 0", req, busy, done); end
    checks++; if (short_o !== 16'd0) begin errors++; $display("FAIL rme_short got=%0d exp=0", short_o); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dut.r_cnt[i] !== 8'd20) begin errors++; $display("FAIL rme_cnt%0d got=%0d exp=20", i, dut.r_cnt[i]); end
    end
    seen_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL rme_no_done got=%0b exp=0", seen_done); end
  endtask

  task automatic test_shortfall();
    logic [2:0]  exp_c [5];
    logic [2:0]  got_c [8];
    int          n;
    logic        fin;
    logic [15:0] sh;
    exp_c = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    n   = 0;
    fin = 1'b0;
    sh  = 16'hFFFF;
    checks++; if (b_low !== 1'b0) begin errors++; $display("FAIL sf_low_init got=%0b exp=0", b_low); end
    b_start  = 1'b1;
    b_amount = 16'd160;
    tick();
    b_start  = 1'b0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      if (b_done) begin
        fin = 1'b1;
        sh  = b_short;
      end else if (b_req) begin
        if (n < 8) got_c[n] = b_code;
        if (b_code == 3'd3) begin
          checks++; if (b_low !== 1'b0) begin errors++; $display("FAIL sf_low_pre25 got=%0b exp=0", b_low); end
        end
        n++;
        tick();
        b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
        if (got_c[n-1] == 3'd3) begin
          checks++; if (b_low !== 1'b1) begin errors++; $display("FAIL sf_low_post25 got=%0b exp=1", b_low); end
        end
      end else begin
        tick();
      end
    end
    checks++; if (fin !== 1'b1) begin errors++; $display("FAIL sf_timeout got done=%0b exp=1", fin); end
    checks++; if (n !== 5) begin errors++; $display("FAIL sf_ncoins got=%0d exp=5", n); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got_c[i] !== exp_c[i]) begin errors++; $display("FAIL sf_code%0d got=%0d exp=%0d", i, got_c[i], exp_c[i]); end
    end
    checks++; if (sh !== 16'd19) begin errors++; $display("FAIL sf_short got=%0d exp=19", sh); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; coin_valid = 1'b0; ack = 1'b0; amount = 16'd0; coin_code = 3'd0;
    b_rst = 1'b1; b_start = 1'b0; b_coin_valid = 1'b0; b_ack = 1'b0; b_amount = 16'd0; b_coin_code = 3'd0;
    tick();
    tick();
    test_reset();
    rst   = 1'b0;
    b_rst = 1'b0;
    tick();
    test_zero_amount();
    test_greedy_65();
    test_ack_stall();
    test_start_while_busy();
    test_coin_insert();
    test_reset_mid_eject();
    test_shortfall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
